// File: rtl/wx_sched_pkg.sv
// Shared types and defaults for the W(x) round-robin scheduler.
// wx_ref is the reference polynomial x^3 + 2x^2 + x + 1 at full 48-bit width.
package wx_sched_pkg;

  localparam int WX_NUM_CH  = 4;
  localparam int WX_DATA_W  = 16;
  localparam int WX_RES_W   = 48;
  localparam int WX_TIMEOUT = 63;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    RETURN = 2'd3
  } wx_state_t;

  function automatic logic [47:0] wx_ref(input logic [15:0] x);
    logic [47:0] xx;
    xx = {32'd0, x};
    return (xx * xx * xx) + (48'd2 * xx * xx) + xx + 48'd1;
  endfunction

endpackage

// File: rtl/wx_rr_pick.sv
// Combinational round-robin pick: first set bit of valid, searching from ptr
// upward with wrap-around modulo NUM_CH.
module wx_rr_pick #(
  parameter int NUM_CH = 4,
  parameter int ID_W   = 2
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [ID_W-1:0]   ptr,
  output logic              found,
  output logic [ID_W-1:0]   winner
);

  logic [ID_W:0]   cand_sum [NUM_CH];
  logic [ID_W-1:0] cand     [NUM_CH];

  // cand[k] is the channel at search offset k; ptr < NUM_CH so one subtract suffices.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, ptr} + (ID_W+1)'(gi);
    assign cand[gi] = (cand_sum[gi] >= (ID_W+1)'(NUM_CH))
                    ? ID_W'(cand_sum[gi] - (ID_W+1)'(NUM_CH))
                    : cand_sum[gi][ID_W-1:0];
  end

  // Walk from the farthest offset down so the nearest valid channel wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (valid[cand[k]]) begin
        found  = 1'b1;
        winner = cand[k];
      end
    end
  end

endmodule

// File: rtl/wx_rr_scheduler.sv
// Shares one sequential W(x) evaluator among NUM_CH AXI-stream requesters,
// one transaction in flight, with a watchdog on the evaluator response.
module wx_rr_scheduler
  import wx_sched_pkg::*;
#(
  parameter int NUM_CH  = WX_NUM_CH,
  parameter int DATA_W  = WX_DATA_W,
  parameter int RES_W   = WX_RES_W,
  parameter int TIMEOUT = WX_TIMEOUT,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      in_clock,
  input  logic                      in_reset_n,
  input  logic [NUM_CH*DATA_W-1:0]  s_tdata,
  input  logic [NUM_CH-1:0]         s_tvalid,
  output logic [NUM_CH-1:0]         s_tready,
  output logic [NUM_CH*RES_W-1:0]   m_tdata,
  output logic [NUM_CH-1:0]         m_tvalid,
  input  logic [NUM_CH-1:0]         m_tready,
  output logic [DATA_W-1:0]         ev_s_tdata,
  output logic                      ev_s_tvalid,
  input  logic                      ev_s_tready,
  input  logic [RES_W-1:0]          ev_m_tdata,
  input  logic                      ev_m_tvalid,
  output logic                      ev_m_tready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  wx_state_t         state;
  logic [ID_W-1:0]   ptr;
  logic [DATA_W-1:0] x_reg;
  logic [RES_W-1:0]  res_reg;
  logic [WD_W-1:0]   wd_cnt;

  logic              found;
  logic [ID_W-1:0]   winner;
  logic              wd_expired;
  logic [DATA_W-1:0] lane_data [NUM_CH];

  wx_rr_pick #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_pick (
    .valid  (s_tvalid),
    .ptr    (ptr),
    .found  (found),
    .winner (winner)
  );

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
    assign lane_data[gi]                 = s_tdata[gi*DATA_W +: DATA_W];
    assign s_tready[gi]                  = (state == IDLE) && found && (winner == ID_W'(gi));
    assign m_tvalid[gi]                  = (state == RETURN) && (grant_id == ID_W'(gi));
    assign m_tdata[gi*RES_W +: RES_W]    = res_reg;
  end

  assign wd_expired  = (wd_cnt == WD_W'(TIMEOUT));
  assign ev_s_tvalid = (state == ISSUE);
  assign ev_s_tdata  = x_reg;
  assign ev_m_tready = (state == WAIT);
  assign busy        = (state != IDLE);
  // A result arriving on the expiry cycle takes precedence over the abort.
  assign timeout_err = (state == WAIT) && !ev_m_tvalid && wd_expired;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      x_reg    <= '0;
      res_reg  <= '0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            x_reg    <= lane_data[winner];
            grant_id <= winner;
            ptr      <= (winner == ID_W'(NUM_CH - 1)) ? '0 : winner + ID_W'(1);
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (ev_s_tready) begin
            wd_cnt <= '0;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (ev_m_tvalid) begin
            res_reg <= ev_m_tdata;
            state   <= RETURN;
          end else if (wd_expired) begin
            state <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        RETURN: begin
          if (m_tready[grant_id]) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wx_rr_scheduler.sv
// Directed bench for wx_rr_scheduler with a behavioural evaluator of
// configurable latency and a hang mode that swallows samples.
module tb_wx_rr_scheduler;
  import wx_sched_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int RW  = 48;
  localparam int TO  = 63;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*DW-1:0] s_tdata;
  logic [NCH-1:0]    s_tvalid;
  logic [NCH-1:0]    s_tready;
  logic [NCH*RW-1:0] m_tdata;
  logic [NCH-1:0]    m_tvalid;
  logic [NCH-1:0]    m_tready;
  logic [DW-1:0]     ev_s_tdata;
  logic              ev_s_tvalid;
  logic              ev_s_tready;
  logic [RW-1:0]     ev_m_tdata;
  logic              ev_m_tvalid;
  logic              ev_m_tready;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wx_rr_scheduler #(
    .NUM_CH  (NCH),
    .DATA_W  (DW),
    .RES_W   (RW),
    .TIMEOUT (TO)
  ) dut (
    .in_clock    (clk),
    .in_reset_n  (rst_n),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .ev_s_tdata  (ev_s_tdata),
    .ev_s_tvalid (ev_s_tvalid),
    .ev_s_tready (ev_s_tready),
    .ev_m_tdata  (ev_m_tdata),
    .ev_m_tvalid (ev_m_tvalid),
    .ev_m_tready (ev_m_tready),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // Evaluator model: accepts when idle, answers after ev_lat cycles.
  int          ev_lat  = 3;
  logic        ev_hang = 1'b0;
  logic        ev_busy;
  logic        ev_valid;
  int          ev_cnt;
  logic [RW-1:0] ev_res;

  assign ev_s_tready = !ev_busy;
  assign ev_m_tvalid = ev_valid;
  assign ev_m_tdata  = ev_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_busy  <= 1'b0;
      ev_valid <= 1'b0;
      ev_cnt   <= 0;
      ev_res   <= '0;
    end else begin
      if (!ev_busy && ev_s_tvalid) begin
        if (!ev_hang) begin
          ev_busy <= 1'b1;
          ev_cnt  <= ev_lat;
          ev_res  <= wx_ref(ev_s_tdata);
        end
      end else if (ev_busy && !ev_valid) begin
        if (ev_cnt <= 1) ev_valid <= 1'b1;
        else ev_cnt <= ev_cnt - 1;
      end else if (ev_valid && ev_m_tready) begin
        ev_valid <= 1'b0;
        ev_busy  <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample on channel ch and expect it to be granted immediately.
  task automatic request(input int ch, input logic [DW-1:0] x);
    s_tdata[ch*DW +: DW] = x;
    s_tvalid = NCH'(1) << ch;
    #1;
    check("req_sready", 64'(s_tready), 64'(1) << ch);
    tick();
    s_tvalid = '0;
    #1;
    check("req_ev_valid", 64'(ev_s_tvalid), 64'd1);
    check("req_ev_data", 64'(ev_s_tdata), 64'(x));
    check("req_grant", 64'(grant_id), 64'(ch));
  endtask

  // Wait for the result on channel ch, check it, and accept it.
  task automatic collect(input int ch, input logic [RW-1:0] exp);
    for (int i = 0; i < 200 && m_tvalid == '0; i++) tick();
    check("res_mvalid", 64'(m_tvalid), 64'(1) << ch);
    check("res_data", 64'(m_tdata[ch*RW +: RW]), 64'(exp));
    check("res_grant", 64'(grant_id), 64'(ch));
    $display("[TB] txn ch=%0d result=%0d", ch, m_tdata[ch*RW +: RW]);
    m_tready = '1;
    tick();
    m_tready = '0;
    #1;
    check("res_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int pulses;
    int first_pulse;
    int mv_seen;
    logic [DW-1:0] fair_x [4];
    logic [RW-1:0] fair_r [4];
    int            fair_g [5];

    s_tdata  = '0;
    s_tvalid = '0;
    m_tready = '0;
    fair_x = '{16'd0, 16'd1, 16'd2, 16'd3};
    fair_r = '{48'd1, 48'd5, 48'd19, 48'd49};
    fair_g = '{0, 1, 2, 3, 0};

    // Reset state
    tick(); tick();
    check("rst_sready", 64'(s_tready), 64'd0);
    check("rst_mvalid", 64'(m_tvalid), 64'd0);
    check("rst_ev_svalid", 64'(ev_s_tvalid), 64'd0);
    check("rst_ev_mready", 64'(ev_m_tready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout", 64'(timeout_err), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_ptr", 64'(dut.ptr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single request: ch2, x=2
    ev_lat = 3;
    request(2, 16'd2);
    check("single_ptr", 64'(dut.ptr), 64'd3);
    collect(2, 48'd19);
    check("single_ptr_after", 64'(dut.ptr), 64'd3);

    // Fairness from ptr=0 with all channels continuously valid
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < NCH; c++) s_tdata[c*DW +: DW] = fair_x[c];
    s_tvalid = '1;
    #1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 20 && s_tready == '0; i++) tick();
      check("fair_grant", 64'(s_tready), 64'(1) << fair_g[k]);
      tick();
      collect(fair_g[k], fair_r[fair_g[k]]);
    end
    s_tvalid = '0;
    tick();

    // Width edge: full-scale sample
    request(1, 16'hFFFF);
    collect(1, 48'd281470681743361);

    // Watchdog: evaluator swallows the sample
    ev_hang = 1'b1;
    request(3, 16'd5);
    tick();
    pulses = 0;
    first_pulse = -1;
    mv_seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (timeout_err) begin
        if (pulses == 0) first_pulse = i;
        pulses++;
      end
      if (m_tvalid != '0) mv_seen++;
      tick();
    end
    check("wd_pulses", 64'(pulses), 64'd1);
    check("wd_when", 64'(first_pulse), 64'd63);
    check("wd_no_mvalid", 64'(mv_seen), 64'd0);
    check("wd_idle", 64'(dut.state), 64'(IDLE));
    ev_hang = 1'b0;
    request(0, 16'd1);
    collect(0, 48'd5);

    // Backpressure on channel 1 for 10 cycles
    request(1, 16'd3);
    for (int i = 0; i < 200 && m_tvalid == '0; i++) tick();
    s_tvalid = 4'b1101;
    m_tready = 4'b1101;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("bp_mvalid", 64'(m_tvalid), 64'd2);
      check("bp_data", 64'(m_tdata[1*RW +: RW]), 64'd49);
      check("bp_sready", 64'(s_tready), 64'd0);
      tick();
    end
    m_tready = 4'b0010;
    #1;
    check("bp_release_mvalid", 64'(m_tvalid), 64'd2);
    tick();
    check("bp_idle", 64'(dut.state), 64'(IDLE));
    s_tvalid = '0;
    m_tready = '0;
    $display("[TB] txn ch=1 backpressure released");
    tick();

    // Reset while waiting for the evaluator
    ev_lat = 20;
    request(2, 16'd1);
    tick(); tick();
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_ev_mready", 64'(ev_m_tready), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sready", 64'(s_tready), 64'd0);
    check("mid_rst_mvalid", 64'(m_tvalid), 64'd0);
    check("mid_rst_ev_svalid", 64'(ev_s_tvalid), 64'd0);
    check("mid_rst_ev_mready", 64'(ev_m_tready), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_timeout", 64'(timeout_err), 64'd0);
    check("mid_rst_grant", 64'(grant_id), 64'd0);
    check("mid_rst_ptr", 64'(dut.ptr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    ev_lat = 3;
    request(3, 16'd2);
    collect(3, 48'd19);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
